cache_mem_arbiter: RTL and testbench

//  Shares one physical-memory port between the I-cache (read-only) and the D-cache (read/write).

---
 rtl/cache_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbiter that shares a single line-granular physical-memory port between an
// instruction cache (read-only fills) and a data cache (fills and writebacks).
// One pmem transaction is outstanding at a time. Simultaneous misses are
// resolved round-robin on the last grantee. Every output comes straight from
// a flop, so reset clears all outputs immediately and no combinational path
// runs from the cache or pmem inputs to any output.
module cache_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int OFS_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    // Clears the line-offset bits so pmem always sees line-aligned addresses.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SERVE_I = 3'd1,
        S_SERVE_D = 3'd2,
        S_RESP_I  = 3'd3,
        S_RESP_D  = 3'd4
    } state_t;

    state_t              r_state,      w_state_nx;
    logic                r_last_gnt,   w_last_gnt_nx;  // 0: I-cache, 1: D-cache
    logic                r_pmem_read,  w_pmem_read_nx;
    logic                r_pmem_write, w_pmem_write_nx;
    logic [ADDR_W-1:0]   r_pmem_addr,  w_pmem_addr_nx;
    logic [LINE_W-1:0]   r_pmem_wdata, w_pmem_wdata_nx;
    logic [LINE_W-1:0]   r_line,       w_line_nx;
    logic                r_iresp,      w_iresp_nx;
    logic                r_dresp,      w_dresp_nx;
    logic [LINE_W-1:0]   r_irdata,     w_irdata_nx;
    logic [LINE_W-1:0]   r_drdata,     w_drdata_nx;

    logic w_req_i;
    logic w_req_d;
    logic w_gnt_i;
    logic w_gnt_d;

    // Round-robin choice: a tie goes to whichever cache was not granted last.
    assign w_req_i = icache_read;
    assign w_req_d = dcache_read | dcache_write;
    assign w_gnt_d = w_req_d & (~w_req_i | ~r_last_gnt);
    assign w_gnt_i = w_req_i & ~w_gnt_d;

    // Next-state, grant latching and next output values.
    always_comb begin
        w_state_nx      = r_state;
        w_last_gnt_nx   = r_last_gnt;
        w_pmem_read_nx  = r_pmem_read;
        w_pmem_write_nx = r_pmem_write;
        w_pmem_addr_nx  = r_pmem_addr;
        w_pmem_wdata_nx = r_pmem_wdata;
        w_line_nx       = r_line;
        w_iresp_nx      = 1'b0;
        w_dresp_nx      = 1'b0;
        w_irdata_nx     = {LINE_W{1'b0}};
        w_drdata_nx     = {LINE_W{1'b0}};
        case (r_state)
            S_IDLE: begin
                w_pmem_read_nx  = 1'b0;
                w_pmem_write_nx = 1'b0;
                w_pmem_addr_nx  = {ADDR_W{1'b0}};
                w_pmem_wdata_nx = {LINE_W{1'b0}};
                if (w_gnt_d) begin
                    // Read and write together is treated as a writeback only.
                    w_state_nx      = S_SERVE_D;
                    w_last_gnt_nx   = 1'b1;
                    w_pmem_read_nx  = ~dcache_write;
                    w_pmem_write_nx = dcache_write;
                    w_pmem_addr_nx  = dcache_address & ALIGN_MASK;
                    w_pmem_wdata_nx = dcache_write ? dcache_wdata : {LINE_W{1'b0}};
                end else if (w_gnt_i) begin
                    w_state_nx      = S_SERVE_I;
                    w_last_gnt_nx   = 1'b0;
                    w_pmem_read_nx  = 1'b1;
                    w_pmem_addr_nx  = icache_address & ALIGN_MASK;
                end else begin
                    w_state_nx      = S_IDLE;
                end
            end
            S_SERVE_I, S_SERVE_D: begin
                // Latched command is held untouched until pmem completes.
                if (pmem_resp) begin
                    w_state_nx      = (r_state == S_SERVE_I) ? S_RESP_I : S_RESP_D;
                    w_pmem_read_nx  = 1'b0;
                    w_pmem_write_nx = 1'b0;
                    w_pmem_addr_nx  = {ADDR_W{1'b0}};
                    w_pmem_wdata_nx = {LINE_W{1'b0}};
                    if (r_pmem_read) begin
                        w_line_nx = pmem_rdata;
                    end else begin
                        w_line_nx = r_line;
                    end
                    if (r_state == S_SERVE_I) begin
                        w_iresp_nx  = 1'b1;
                        w_irdata_nx = w_line_nx;
                    end else begin
                        w_dresp_nx  = 1'b1;
                        w_drdata_nx = w_line_nx;
                    end
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_RESP_I, S_RESP_D: begin
                w_state_nx      = S_IDLE;
                w_pmem_read_nx  = 1'b0;
                w_pmem_write_nx = 1'b0;
            end
            default: begin
                w_state_nx      = S_IDLE;
                w_pmem_read_nx  = 1'b0;
                w_pmem_write_nx = 1'b0;
                w_pmem_addr_nx  = {ADDR_W{1'b0}};
                w_pmem_wdata_nx = {LINE_W{1'b0}};
            end
        endcase
    end

    // State register and round-robin history; reset lets the I-cache win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_last_gnt <= w_last_gnt_nx;
        end
    end

    // Registered pmem command, line register and cache response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= {ADDR_W{1'b0}};
            r_pmem_wdata <= {LINE_W{1'b0}};
            r_line       <= {LINE_W{1'b0}};
            r_iresp      <= 1'b0;
            r_dresp      <= 1'b0;
            r_irdata     <= {LINE_W{1'b0}};
            r_drdata     <= {LINE_W{1'b0}};
        end else begin
            r_pmem_read  <= w_pmem_read_nx;
            r_pmem_write <= w_pmem_write_nx;
            r_pmem_addr  <= w_pmem_addr_nx;
            r_pmem_wdata <= w_pmem_wdata_nx;
            r_line       <= w_line_nx;
            r_iresp      <= w_iresp_nx;
            r_dresp      <= w_dresp_nx;
            r_irdata     <= w_irdata_nx;
            r_drdata     <= w_drdata_nx;
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_addr;
    assign pmem_wdata   = r_pmem_wdata;
    assign icache_resp  = r_iresp;
    assign icache_rdata = r_irdata;
    assign dcache_resp  = r_dresp;
    assign dcache_rdata = r_drdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus random
// I/D traffic checked against a transaction-level reference model.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         icache_read;
    logic [15:0]  icache_address;
    logic [127:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [15:0]  dcache_address;
    logic [127:0] dcache_wdata;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [403:0] all_out;
    assign all_out = {icache_rdata, icache_resp, dcache_rdata, dcache_resp,
                      pmem_read, pmem_write, pmem_address, pmem_wdata};

    cache_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        icache_read = 1'b0; icache_address = 16'h0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = 16'h0;
        dcache_wdata = 128'h0; pmem_rdata = 128'h0; pmem_resp = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Pmem responder: waits (bounded) for a command, holds it lat cycles, then pulses pmem_resp.
    task automatic run_pmem(input int lat, input logic [127:0] data, input bit perturb,
                            output int waited, output logic [15:0] a, output logic rd,
                            output logic wr, output logic [127:0] wd, output bit stable,
                            output bit ok);
        waited = 0;
        while (!(pmem_read || pmem_write) && waited < 50) begin
            tick();
            waited++;
        end
        ok = pmem_read || pmem_write;
        a = pmem_address; rd = pmem_read; wr = pmem_write; wd = pmem_wdata;
        stable = 1'b1;
        if (ok) begin
            if (perturb) begin
                icache_address = 16'($urandom);
                dcache_address = 16'($urandom);
                dcache_wdata   = {4{$urandom}};
            end
            for (int k = 0; k < lat; k++) begin
                tick();
                if (pmem_read !== rd || pmem_write !== wr || pmem_address !== a || pmem_wdata !== wd)
                    stable = 1'b0;
            end
            pmem_resp = 1'b1; pmem_rdata = data;
            tick();
            pmem_resp = 1'b0; pmem_rdata = 128'h0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        icache_read = 1'b1; dcache_write = 1'b1; pmem_resp = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (all_out !== 404'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        clear_inputs();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (all_out !== 404'h0) begin
            n_fail++; $display("FAIL idle_after_reset: got %h required 0", all_out);
        end
    endtask

    task automatic test_icache_read;
        int w; logic [15:0] a; logic rd, wr; logic [127:0] wd; bit st, ok;
        logic [127:0] pat;
        pat = {16{8'hA5}};
        do_reset();
        icache_read = 1'b1; icache_address = 16'h1237;
        run_pmem(2, pat, 1'b0, w, a, rd, wr, wd, st, ok);
        n_cmp++;
        if (!ok || w != 1) begin n_fail++; $display("FAIL i_cmd_latency: got %0d required 1", w); end
        n_cmp++;
        if (a !== 16'h1230) begin n_fail++; $display("FAIL i_addr: got %h required 1230", a); end
        n_cmp++;
        if ({rd, wr} !== 2'b10 || !st) begin
            n_fail++; $display("FAIL i_cmd_hold: got rd=%b wr=%b stable=%b required 1 0 1", rd, wr, st);
        end
        n_cmp++;
        if ({icache_resp, dcache_resp, pmem_read, pmem_write} !== 4'b1000) begin
            n_fail++; $display("FAIL i_resp_cycle: got %b required 1000",
                               {icache_resp, dcache_resp, pmem_read, pmem_write});
        end
        n_cmp++;
        if (icache_rdata !== pat) begin n_fail++; $display("FAIL i_rdata: got %h required %h", icache_rdata, pat); end
        icache_read = 1'b0;
        tick();
        n_cmp++;
        if (icache_resp !== 1'b0 || icache_rdata !== 128'h0 || pmem_read !== 1'b0) begin
            n_fail++; $display("FAIL i_resp_one_cycle: got resp=%b rdata=%h required 0", icache_resp, icache_rdata);
        end
    endtask

    task automatic test_tie;
        int w; logic [15:0] a; logic rd, wr; logic [127:0] wd; bit st, ok;
        logic [127:0] di, dd;
        di = {4{32'h1111_2222}}; dd = {4{32'h3333_4444}};
        do_reset();
        icache_read = 1'b1; icache_address = 16'h2005;
        dcache_read = 1'b1; dcache_address = 16'h3007;
        run_pmem(1, di, 1'b0, w, a, rd, wr, wd, st, ok);
        n_cmp++;
        if (!ok || a !== 16'h2000) begin n_fail++; $display("FAIL tie1_i_first: got %h required 2000", a); end
        n_cmp++;
        if ({icache_resp, dcache_resp} !== 2'b10 || icache_rdata !== di) begin
            n_fail++; $display("FAIL tie1_i_resp: got %b %h required 10 %h", {icache_resp, dcache_resp}, icache_rdata, di);
        end
        icache_read = 1'b0;
        run_pmem(3, dd, 1'b0, w, a, rd, wr, wd, st, ok);
        n_cmp++;
        if (!ok || w != 2 || a !== 16'h3000 || rd !== 1'b1) begin
            n_fail++; $display("FAIL tie1_d_next: got gap=%0d addr=%h rd=%b required 2 3000 1", w, a, rd);
        end
        n_cmp++;
        if ({icache_resp, dcache_resp} !== 2'b01 || dcache_rdata !== dd) begin
            n_fail++; $display("FAIL tie1_d_resp: got %b %h required 01 %h", {icache_resp, dcache_resp}, dcache_rdata, dd);
        end
        dcache_read = 1'b0;
        tick();
        icache_read = 1'b1; icache_address = 16'h0A1F;
        run_pmem(1, di, 1'b0, w, a, rd, wr, wd, st, ok);
        icache_read = 1'b0;
        tick();
        icache_read = 1'b1; icache_address = 16'h7777;
        dcache_read = 1'b1; dcache_address = 16'h8888;
        run_pmem(2, dd, 1'b0, w, a, rd, wr, wd, st, ok);
        n_cmp++;
        if (!ok || a !== 16'h8880 || dcache_resp !== 1'b1) begin
            n_fail++; $display("FAIL tie2_d_first: got addr=%h dresp=%b required 8880 1", a, dcache_resp);
        end
        dcache_read = 1'b0;
        run_pmem(2, di, 1'b0, w, a, rd, wr, wd, st, ok);
        n_cmp++;
        if (!ok || w != 2 || a !== 16'h7770 || icache_resp !== 1'b1) begin
            n_fail++; $display("FAIL tie2_i_next: got gap=%0d addr=%h iresp=%b required 2 7770 1", w, a, icache_resp);
        end
        icache_read = 1'b0;
        tick();
    endtask

    task automatic test_dwrite;
        int w; logic [15:0] a; logic rd, wr; logic [127:0] wd; bit st, ok;
        int extra;
        do_reset();
        dcache_write = 1'b1; dcache_address = 16'h4008; dcache_wdata = 128'h1;
        run_pmem(3, {4{$urandom}}, 1'b1, w, a, rd, wr, wd, st, ok);
        n_cmp++;
        if (!ok || a !== 16'h4000 || {rd, wr} !== 2'b01 || wd !== 128'h1) begin
            n_fail++; $display("FAIL dwr_cmd: got addr=%h rd=%b wr=%b wdata=%h required 4000 0 1 1", a, rd, wr, wd);
        end
        n_cmp++;
        if (!st) begin n_fail++; $display("FAIL dwr_stable: got 0 required 1"); end
        n_cmp++;
        if ({icache_resp, dcache_resp, pmem_write} !== 3'b010) begin
            n_fail++; $display("FAIL dwr_resp: got %b required 010", {icache_resp, dcache_resp, pmem_write});
        end
        dcache_write = 1'b0; dcache_wdata = 128'h0;
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (dcache_resp || icache_resp || pmem_read || pmem_write) extra++;
        end
        n_cmp++;
        if (extra != 0) begin n_fail++; $display("FAIL dwr_single: got %0d extra cycles required 0", extra); end
    endtask

    task automatic test_reset_mid;
        int bad;
        do_reset();
        dcache_read = 1'b1; dcache_address = 16'h6543;
        tick();
        n_cmp++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h6540) begin
            n_fail++; $display("FAIL rmid_cmd: got rd=%b addr=%h required 1 6540", pmem_read, pmem_address);
        end
        tick();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_out !== 404'h0) begin n_fail++; $display("FAIL rmid_async_clear: got %h required 0", all_out); end
        dcache_read = 1'b0;
        tick();
        rst_n = 1'b1;
        pmem_resp = 1'b1; pmem_rdata = {4{$urandom}};
        tick();
        pmem_resp = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (all_out !== 404'h0) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL rmid_late_resp: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_spurious_both;
        int w; logic [15:0] a; logic rd, wr; logic [127:0] wd; bit st, ok;
        logic [127:0] wdat;
        int bad;
        do_reset();
        pmem_resp = 1'b1; pmem_rdata = {4{$urandom}};
        tick();
        pmem_resp = 1'b0; pmem_rdata = 128'h0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (all_out !== 404'h0) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL spurious_idle: got %0d active cycles required 0", bad); end
        wdat = {4{$urandom}};
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h5013; dcache_wdata = wdat;
        run_pmem(2, {4{$urandom}}, 1'b0, w, a, rd, wr, wd, st, ok);
        n_cmp++;
        if (!ok || w != 1 || {rd, wr} !== 2'b01 || a !== 16'h5010 || wd !== wdat) begin
            n_fail++; $display("FAIL both_is_write: got rd=%b wr=%b addr=%h wdata=%h required 0 1 5010 %h", rd, wr, a, wd, wdat);
        end
        n_cmp++;
        if ({icache_resp, dcache_resp} !== 2'b01) begin
            n_fail++; $display("FAIL both_resp: got %b required 01", {icache_resp, dcache_resp});
        end
        dcache_read = 1'b0; dcache_write = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (pmem_read || pmem_write || dcache_resp || icache_resp) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL both_no_read_after: got %0d active cycles required 0", bad); end
    endtask

    // Random traffic against a transaction-level model: requests, round-robin
    // grant decisions, one pmem transaction in flight, one response per request.
    task automatic test_random;
        bit i_pend, d_pend, prev_i, prev_d, last_gnt, busy, busy0, detected, cmd, g;
        bit resp_due, resp_now, resp_who, expect_cmd, idle_now;
        logic [15:0] i_addr, d_addr, c_addr;
        logic d_rd, d_wr, c_rd, c_wr;
        logic [127:0] d_wd, c_wd, c_data, resp_data, line, got;
        int remain, i_others, d_others, issued, served, op;
        i_pend = 0; d_pend = 0; prev_i = 0; prev_d = 0; last_gnt = 1; busy = 0;
        resp_due = 0; resp_who = 0; expect_cmd = 0; line = 128'h0; remain = 0;
        i_others = 0; d_others = 0; issued = 0; served = 0;
        i_addr = 16'h0; d_addr = 16'h0; d_rd = 0; d_wr = 0; d_wd = 128'h0;
        c_addr = 16'h0; c_rd = 0; c_wr = 0; c_wd = 128'h0; c_data = 128'h0; resp_data = 128'h0;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            pmem_resp = 1'b0; pmem_rdata = {4{$urandom}};
            cmd = pmem_read | pmem_write;
            resp_now = resp_due; resp_due = 0; detected = 0; busy0 = busy;
            n_cmp++;
            if ((pmem_read && pmem_write) || (icache_resp && dcache_resp)) begin
                n_fail++; $display("FAIL rnd_exclusive: cycle %0d rd=%b wr=%b iresp=%b dresp=%b", cyc, pmem_read, pmem_write, icache_resp, dcache_resp);
            end
            n_cmp++;
            if ({icache_resp, dcache_resp} !== (resp_now ? (resp_who ? 2'b01 : 2'b10) : 2'b00)) begin
                n_fail++; $display("FAIL rnd_resp: cycle %0d got %b required %b", cyc, {icache_resp, dcache_resp},
                                   resp_now ? (resp_who ? 2'b01 : 2'b10) : 2'b00);
            end
            if (resp_now) begin
                got = resp_who ? dcache_rdata : icache_rdata;
                n_cmp++;
                if (got !== resp_data) begin n_fail++; $display("FAIL rnd_rdata: cycle %0d got %h required %h", cyc, got, resp_data); end
            end
            n_cmp++;
            if ((!icache_resp && icache_rdata !== 128'h0) || (!dcache_resp && dcache_rdata !== 128'h0)) begin
                n_fail++; $display("FAIL rnd_rdata_zero: cycle %0d got %h %h required 0", cyc, icache_rdata, dcache_rdata);
            end
            if (busy) begin
                n_cmp++;
                if (pmem_read !== c_rd || pmem_write !== c_wr || pmem_address !== c_addr || pmem_wdata !== c_wd) begin
                    n_fail++; $display("FAIL rnd_cmd_stable: cycle %0d got %b%b %h required %b%b %h", cyc, pmem_read, pmem_write, pmem_address, c_rd, c_wr, c_addr);
                end
                remain--;
                if (remain == 0) begin
                    pmem_resp = 1'b1; pmem_rdata = c_data; busy = 0;
                    resp_due = 1; resp_who = g;
                    resp_data = c_rd ? c_data : line;
                    if (c_rd) line = c_data;
                end
            end else begin
                n_cmp++;
                if (cmd !== expect_cmd) begin n_fail++; $display("FAIL rnd_cmd_start: cycle %0d got %b required %b", cyc, cmd, expect_cmd); end
                if (cmd) begin
                    detected = 1;
                    g = (prev_i && prev_d) ? !last_gnt : prev_d;
                    last_gnt = g;
                    c_addr = (g ? d_addr : i_addr) & 16'hFFF0;
                    c_wr = g && d_wr;
                    c_rd = !c_wr;
                    c_wd = pmem_wdata;
                    n_cmp++;
                    if ({pmem_address, pmem_read, pmem_write} !== {c_addr, c_rd, c_wr}) begin
                        n_fail++; $display("FAIL rnd_grant: cycle %0d got %h %b%b required %h %b%b", cyc, pmem_address, pmem_read, pmem_write, c_addr, c_rd, c_wr);
                    end
                    if (c_wr) begin
                        n_cmp++;
                        if (pmem_wdata !== d_wd) begin n_fail++; $display("FAIL rnd_wdata: cycle %0d got %h required %h", cyc, pmem_wdata, d_wd); end
                    end
                    if (g) begin d_others = 0; if (i_pend) i_others++; end
                    else begin i_others = 0; if (d_pend) d_others++; end
                    n_cmp++;
                    if (i_others > 1 || d_others > 1) begin
                        n_fail++; $display("FAIL rnd_starvation: cycle %0d got waits %0d/%0d required <=1", cyc, i_others, d_others);
                    end
                    busy = 1; remain = 1 + int'($urandom % 20); c_data = {4{$urandom}};
                end
            end
            if (resp_now && ($urandom % 2 == 0)) pmem_resp = 1'b1;
            idle_now = !busy0 && !detected && !resp_now;
            if (icache_resp && i_pend) begin i_pend = 0; served++; end
            if (dcache_resp && d_pend) begin d_pend = 0; served++; end
            if (!i_pend && !icache_resp && cyc < 3500 && ($urandom % 3 == 0)) begin
                i_pend = 1; i_addr = 16'($urandom); issued++;
            end
            if (!d_pend && !dcache_resp && cyc < 3500 && ($urandom % 3 == 0)) begin
                d_pend = 1; d_addr = 16'($urandom); d_wd = {4{$urandom}}; issued++;
                op = int'($urandom % 3);
                d_rd = (op != 1); d_wr = (op != 0);
            end
            icache_read = i_pend; icache_address = i_addr;
            dcache_read = d_pend && d_rd; dcache_write = d_pend && d_wr;
            dcache_address = d_addr; dcache_wdata = d_wd;
            expect_cmd = idle_now && (i_pend || d_pend);
            prev_i = i_pend; prev_d = d_pend;
        end
        n_cmp++;
        if (i_pend || d_pend || issued != served) begin
            n_fail++; $display("FAIL rnd_all_served: got %0d served of %0d issued, pending %b%b", served, issued, i_pend, d_pend);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_icache_read();
        test_tie();
        test_dwrite();
        test_reset_mid();
        test_spurious_both();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
